// File: rtl/axis_serial_adc_rx.sv
// Serial ADC front end: strobes a conversion, clocks 24 bits out of the converter
// and presents the sample as a single AXI-Stream beat.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | waiting for adc_trigger
//   CONVERT | adc_cnv high, conversion counter running down
//   SHIFT   | adc_csn low, adc_sclk running, sdo shifted in on rising edges
//   OUTPUT  | m_axis_tvalid high, tdata held until the handshake
module axis_serial_adc_rx #(
  parameter int AXIS_DATA_WIDTH = 24,
  parameter int CONV_CYCLES     = 16,
  parameter int SCLK_DIV        = 2
) (
  input  logic                       m_axis_aclk,
  input  logic                       m_axis_areset,
  input  logic                       adc_trigger,
  input  logic                       adc_sdo,
  output logic                       adc_cnv,
  output logic                       adc_csn,
  output logic                       adc_sclk,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       overrun
);

  localparam int          SAMPLE_BITS = 24;
  localparam logic [7:0]  LP_CONV     = 8'(CONV_CYCLES);
  localparam logic [3:0]  LP_DIV      = 4'(SCLK_DIV);
  localparam logic [4:0]  LP_BITS     = 5'(SAMPLE_BITS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONVERT,
    S_SHIFT,
    S_OUTPUT
  } state_t;

  state_t                     r_state;
  state_t                     w_next_state;

  logic [7:0]                 r_conv_cnt;
  logic [3:0]                 r_div_cnt;
  logic [4:0]                 r_bit_cnt;
  logic [SAMPLE_BITS-1:0]     r_shift;
  logic                       r_cnv;
  logic                       r_csn;
  logic                       r_sclk;
  logic                       r_tvalid;
  logic                       r_overrun;
  logic [AXIS_DATA_WIDTH-1:0] r_tdata;
  logic [AXIS_DATA_WIDTH-1:0] w_sample;

  logic                       w_conv_tc;
  logic                       w_half_tc;
  logic                       w_sclk_rise;
  logic                       w_sclk_fall;
  logic                       w_last_fall;
  logic                       w_handshake;

  assign w_conv_tc   = (r_conv_cnt == 8'd1);
  assign w_half_tc   = (r_state == S_SHIFT) && (r_div_cnt == 4'd1);
  assign w_sclk_rise = w_half_tc && !r_sclk;
  assign w_sclk_fall = w_half_tc && r_sclk;
  assign w_last_fall = w_sclk_fall && (r_bit_cnt == 5'd1);
  assign w_handshake = r_tvalid && m_axis_tready;

  // Map the 24-bit sample onto the stream width
  generate
    if (AXIS_DATA_WIDTH < SAMPLE_BITS) begin : g_trunc
      assign w_sample = r_shift[SAMPLE_BITS-1 -: AXIS_DATA_WIDTH];
    end else if (AXIS_DATA_WIDTH > SAMPLE_BITS) begin : g_sext
      assign w_sample = {{(AXIS_DATA_WIDTH-SAMPLE_BITS){r_shift[SAMPLE_BITS-1]}}, r_shift};
    end else begin : g_pass
      assign w_sample = r_shift;
    end
  endgenerate

  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (adc_trigger) w_next_state = S_CONVERT;
      S_CONVERT: if (w_conv_tc)   w_next_state = S_SHIFT;
      S_SHIFT:   if (w_last_fall) w_next_state = S_OUTPUT;
      S_OUTPUT:  if (w_handshake) w_next_state = S_IDLE;
      default:                    w_next_state = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it glitch-free
  always_ff @(posedge m_axis_aclk or posedge m_axis_areset) begin
    if (m_axis_areset) begin
      r_cnv      <= 1'b0;
      r_csn      <= 1'b1;
      r_tvalid   <= 1'b0;
      r_overrun  <= 1'b0;
      r_conv_cnt <= 8'd0;
      r_div_cnt  <= 4'd0;
      r_bit_cnt  <= 5'd0;
      r_sclk     <= 1'b0;
      r_shift    <= '0;
      r_tdata    <= '0;
    end else begin
      r_cnv     <= (w_next_state == S_CONVERT);
      r_csn     <= (w_next_state != S_SHIFT);
      r_tvalid  <= (w_next_state == S_OUTPUT);
      r_overrun <= r_overrun | (adc_trigger && (r_state != S_IDLE));

      case (r_state)
        S_IDLE: begin
          if (adc_trigger) begin
            r_conv_cnt <= LP_CONV;
          end
        end
        S_CONVERT: begin
          if (w_conv_tc) begin
            r_conv_cnt <= 8'd0;
            r_bit_cnt  <= LP_BITS;
            r_div_cnt  <= LP_DIV;
            r_sclk     <= 1'b0;
          end else begin
            r_conv_cnt <= r_conv_cnt - 8'd1;
          end
        end
        S_SHIFT: begin
          if (w_half_tc) begin
            r_div_cnt <= LP_DIV;
            r_sclk    <= ~r_sclk;
          end else begin
            r_div_cnt <= r_div_cnt - 4'd1;
          end
          if (w_sclk_rise) begin
            r_shift <= {r_shift[SAMPLE_BITS-2:0], adc_sdo};
          end
          if (w_sclk_fall) begin
            r_bit_cnt <= r_bit_cnt - 5'd1;
          end
          if (w_last_fall) begin
            r_tdata <= w_sample;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign adc_cnv       = r_cnv;
  assign adc_csn       = r_csn;
  assign adc_sclk      = r_sclk;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign overrun       = r_overrun;

endmodule
